// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small write FIFO, bit period latched per frame.
// Define UART_TX_PARITY_EN to add input parity_odd and a parity bit between the data and stop bits.
module uart_tx_fifo #(
    parameter int FIFO_AW    = 2,
    parameter int PRESCALE_W = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [7:0]            wdata,
    input  logic                  wr,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  tx,
    output logic [2:0]            o_dbg_state
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [FIFO_AW-1:0]    r_wptr;
    logic [FIFO_AW-1:0]    r_rptr;
    logic [FIFO_AW:0]      r_count;
    logic                  r_ovf;

    state_t                r_state;
    logic [7:0]            r_shift;
    logic [PRESCALE_W-1:0] r_period;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [2:0]            r_bit;
    logic                  r_tx;

    state_t                w_state_nxt;
    logic [7:0]            w_shift_nxt;
    logic [PRESCALE_W-1:0] w_period_nxt;
    logic [PRESCALE_W-1:0] w_cnt_nxt;
    logic [2:0]            w_bit_nxt;
    logic                  w_tx_nxt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_cnt_zero;
    logic [7:0]            w_head;
    logic [PRESCALE_W-1:0] w_p;

`ifdef UART_TX_PARITY_EN
    logic                  r_par;
    logic                  w_par_nxt;
`endif

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_push     = wr & ~w_full;
    assign w_head     = r_mem[r_rptr];
    assign w_cnt_zero = (r_cnt == '0);
    // A prescale of 0 would give no bit time at all; it runs as 1 cycle per bit.
    assign w_p        = (prescale == '0) ? PRESCALE_W'(1) : prescale;

    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_ovf;
    assign tx          = r_tx;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A dropped write outranks a clear in the same cycle.
            if (wr & w_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_period_nxt = r_period;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_tx_nxt     = r_tx;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_cnt_nxt   = r_period - 1'b1;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt = r_period - 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 1'b1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                    w_cnt_nxt   = r_period - 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Frame start is shared by IDLE and STOP so back-to-back frames have no gap.
        if (w_pop) begin
            w_state_nxt  = S_START;
            w_tx_nxt     = 1'b0;
            w_shift_nxt  = w_head;
            w_period_nxt = w_p;
            w_cnt_nxt    = w_p - 1'b1;
            w_bit_nxt    = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_par_nxt    = (^w_head) ^ parity_odd;
`endif
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_period <= PRESCALE_W'(1);
            r_cnt    <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_period <= w_period_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_tx     <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed stimulus for uart_tx_fifo against a queue-based line model.
// The model keeps the FIFO as a byte queue and each frame as a queue of per-cycle line levels.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [PW-1:0] prescale;
    logic [7:0]    wdata;
    logic          wr;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic          busy;
    logic          overflow;
    logic          tx;
    logic [2:0]    dbg_state;
`ifdef UART_TX_PARITY_EN
    logic          parity_odd;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic       m_line[$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       m_empty = 1'b1;
    logic       m_full  = 1'b0;

    uart_tx_fifo #(.FIFO_AW(AW), .PRESCALE_W(PW)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .prescale    (prescale),
        .wdata       (wdata),
        .wr          (wr),
`ifdef UART_TX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .tx          (tx),
        .o_dbg_state (dbg_state)
    );

    always #5 HCLK = ~HCLK;

    // One clock edge: advance the model with the inputs as sampled, then settle for checking.
    task automatic tick();
        int         pre_sz;
        int         p;
        logic [7:0] b;
        @(posedge HCLK);
        if (HRESET) begin
            exp_q.delete();
            m_line.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            pre_sz = exp_q.size();
            if (m_line.size() == 0 && pre_sz > 0) begin
                b = exp_q.pop_front();
                p = (prescale == 0) ? 1 : int'(prescale);
                repeat (p) m_line.push_back(1'b0);
                for (int k = 0; k < 8; k++) repeat (p) m_line.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
                repeat (p) m_line.push_back((^b) ^ parity_odd);
`endif
                repeat (p) m_line.push_back(1'b1);
            end
            if (wr && pre_sz == DEPTH) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (wr && pre_sz < DEPTH) exp_q.push_back(wdata);
            if (m_line.size() > 0) begin
                m_tx   = m_line.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
        m_empty = (exp_q.size() == 0);
        m_full  = (exp_q.size() == DEPTH);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        wr = 1'b0; ovf_clr = 1'b0; wdata = 8'h00; prescale = 16'd16;
        repeat (3) tick();
        n_vec++;
        if ({tx, empty, full, busy, overflow} !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_held: tx/empty/full/busy/ovf got %b want 11000", {tx, empty, full, busy, overflow});
        end
        HRESET = 1'b0;
        tick();
        n_vec++;
        if ({tx, empty, full, busy, overflow} !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_release: tx/empty/full/busy/ovf got %b want 11000", {tx, empty, full, busy, overflow});
        end
        n_vec++;
        if (dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: dbg_state got %0d want 0", dbg_state);
        end
    endtask

    task automatic test_single();
        int   drop_c = -1;
        logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        prescale = 16'd16; wdata = 8'h41; wr = 1'b1;
        tick();
        wr = 1'b0;
        n_vec++;
        if (empty !== 1'b0) begin
            n_err++;
            $display("FAIL single_empty: empty got %b want 0", empty);
        end
        for (int c = 0; c < FB * 16 + 20; c++) begin
            tick();
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL single_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
            if (c == 0) begin
                n_vec++;
                if (tx !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_fall: tx got %b want 0", tx);
                end
            end
            if (c % 16 == 8 && c / 16 < 9) begin
                n_vec++;
                if (tx !== exp_bits[c / 16]) begin
                    n_err++;
                    $display("FAIL single_bit%0d: tx got %b want %b", c / 16, tx, exp_bits[c / 16]);
                end
            end
            if (c == (FB - 1) * 16 + 8) begin
                n_vec++;
                if (tx !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_stop: tx got %b want 1", tx);
                end
            end
            if (drop_c < 0 && busy === 1'b0) drop_c = c;
        end
        n_vec++;
        if (drop_c != FB * 16) begin
            n_err++;
            $display("FAIL single_busy_len: busy dropped at %0d want %0d", drop_c, FB * 16);
        end
    endtask

    task automatic test_back_to_back();
        int busy_n = 0;
        prescale = 16'd16; wdata = 8'h55; wr = 1'b1;
        tick();
        wdata = 8'hAA;
        for (int c = 0; c < 2 * FB * 16 + 20; c++) begin
            tick();
            wr = 1'b0;
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL b2b_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
            if (busy === 1'b1) busy_n++;
            if (c == FB * 16 - 1 || c == FB * 16) begin
                n_vec++;
                if (tx !== (c == FB * 16 - 1)) begin
                    n_err++;
                    $display("FAIL b2b_seam c=%0d: tx got %b want %b", c, tx, (c == FB * 16 - 1));
                end
            end
        end
        n_vec++;
        if (busy_n != 2 * FB * 16) begin
            n_err++;
            $display("FAIL b2b_busy_len: busy cycles got %0d want %0d", busy_n, 2 * FB * 16);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        logic [7:0] got [5];
        int busy_n = 0;
        int c, f, r;
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) got[i] = 8'h00;
        prescale = 16'd4;
        for (int i = 0; i < 1 + 5 * FB * 4 + 20; i++) begin
            wr = (i < 6);
            if (i < 6) wdata = bytes[i];
            tick();
            c = i - 1;
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL ovf_model i=%0d: tx/busy/empty/full/ovf got %b want %b", i, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
            if (i == 4) begin
                n_vec++;
                if (full !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_full: full got %b want 1", full);
                end
            end
            if (i == 5) begin
                n_vec++;
                if (overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_set: overflow got %b want 1", overflow);
                end
            end
            if (c >= 0 && busy === 1'b1) busy_n++;
            if (c >= 0 && c < 5 * FB * 4) begin
                f = c / (FB * 4);
                r = c % (FB * 4);
                if (r >= 4 && r < 36 && (r - 4) % 4 == 2) got[f][(r - 4) / 4] = tx;
            end
        end
        wr = 1'b0;
        n_vec++;
        if (busy_n != 5 * FB * 4) begin
            n_err++;
            $display("FAIL ovf_frames: busy cycles got %0d want %0d", busy_n, 5 * FB * 4);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (got[i] !== bytes[i]) begin
                n_err++;
                $display("FAIL ovf_byte%0d: decoded got %h want %h", i, got[i], bytes[i]);
            end
        end
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: overflow got %b want 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_vec++;
        if (overflow !== 1'b0 || m_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: overflow got %b want 0", overflow);
        end
    endtask

    task automatic test_prescale();
        logic [7:0] b0, b1, b2;
        int busy_n = 0;
        b0 = 8'($urandom_range(0, 255));
        prescale = 16'd0; wdata = b0; wr = 1'b1;
        tick();
        wr = 1'b0;
        for (int c = 0; c < FB + 5; c++) begin
            tick();
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL ps0_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
            if (busy === 1'b1) busy_n++;
            if (c >= 1 && c <= 8) begin
                n_vec++;
                if (tx !== b0[c - 1]) begin
                    n_err++;
                    $display("FAIL ps0_bit%0d: tx got %b want %b", c - 1, tx, b0[c - 1]);
                end
            end
        end
        n_vec++;
        if (busy_n != FB) begin
            n_err++;
            $display("FAIL ps0_len: busy cycles got %0d want %0d", busy_n, FB);
        end

        busy_n = 0;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        prescale = 16'd8; wdata = b1; wr = 1'b1;
        tick();
        wdata = b2;
        for (int c = 0; c < FB * 10 + 10; c++) begin
            if (c == 20) prescale = 16'd2;
            tick();
            wr = 1'b0;
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL pschg_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
            if (busy === 1'b1) busy_n++;
            if (c >= 8 && c < 72 && (c - 8) % 8 == 4) begin
                n_vec++;
                if (tx !== b1[(c - 8) / 8]) begin
                    n_err++;
                    $display("FAIL pschg_f1bit%0d: tx got %b want %b", (c - 8) / 8, tx, b1[(c - 8) / 8]);
                end
            end
            if (c == FB * 8) begin
                n_vec++;
                if (tx !== 1'b0) begin
                    n_err++;
                    $display("FAIL pschg_f2start: tx got %b want 0", tx);
                end
            end
            if (c >= FB * 8 + 2 && c < FB * 8 + 18 && (c - FB * 8 - 2) % 2 == 0) begin
                n_vec++;
                if (tx !== b2[(c - FB * 8 - 2) / 2]) begin
                    n_err++;
                    $display("FAIL pschg_f2bit%0d: tx got %b want %b", (c - FB * 8 - 2) / 2, tx, b2[(c - FB * 8 - 2) / 2]);
                end
            end
        end
        n_vec++;
        if (busy_n != FB * 10) begin
            n_err++;
            $display("FAIL pschg_len: busy cycles got %0d want %0d", busy_n, FB * 10);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b3;
        logic [7:0] got = 8'h00;
        int busy_n = 0;
        prescale = 16'd4; wdata = 8'($urandom_range(0, 255)); wr = 1'b1;
        tick();
        wdata = 8'($urandom_range(0, 255));
        for (int c = 0; c < 18; c++) begin
            tick();
            wr = 1'b0;
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL rmid_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
        end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        n_vec++;
        if ({tx, empty, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL rmid_abort: tx/empty/busy got %b want 110", {tx, empty, busy});
        end
        for (int c = 0; c < 50; c++) begin
            tick();
            n_vec++;
            if ({tx, busy, empty} !== 3'b101 || {m_tx, m_busy} !== 2'b10) begin
                n_err++;
                $display("FAIL rmid_quiet c=%0d: tx/busy/empty got %b want 101", c, {tx, busy, empty});
            end
        end
        b3 = 8'($urandom_range(0, 255));
        wdata = b3; wr = 1'b1;
        tick();
        wr = 1'b0;
        for (int c = 0; c < FB * 4 + 10; c++) begin
            tick();
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL rmid_new_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
            if (busy === 1'b1) busy_n++;
            if (c >= 4 && c < 36 && (c - 4) % 4 == 2) got[(c - 4) / 4] = tx;
        end
        n_vec++;
        if (got !== b3 || busy_n != FB * 4) begin
            n_err++;
            $display("FAIL rmid_new_frame: byte got %h want %h, busy cycles got %0d want %0d", got, b3, busy_n, FB * 4);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            wr      = ($urandom_range(0, 5) == 0);
            wdata   = 8'($urandom_range(0, 255));
            ovf_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 99) == 0) prescale = 16'($urandom_range(0, 3));
`ifdef UART_TX_PARITY_EN
            parity_odd = 1'($urandom_range(0, 1));
`endif
            tick();
            n_vec++;
            if ({tx, busy, empty, full, overflow} !== {m_tx, m_busy, m_empty, m_full, m_ovf}) begin
                n_err++;
                $display("FAIL random_model c=%0d: tx/busy/empty/full/ovf got %b want %b", c, {tx, busy, empty, full, overflow}, {m_tx, m_busy, m_empty, m_full, m_ovf});
            end
        end
        wr = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        wr = 1'b0;
        ovf_clr = 1'b0;
        wdata = 8'h00;
        prescale = 16'd16;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_prescale();
        test_reset_mid();
        prescale = 16'd2;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
